vga_scan_out: RTL
=================

Name: vga_scan_out

Overview:
- Display back-end directly downstream of the graphics ASIC.
- Generates 640x480@60 Hz VGA timing from the system clock using a pixel-enable divider.
- Issues one `vga_ready` strobe per active pixel; the ASIC uses it to advance its pixel counters and present the pixel colour.
- Registers the returned 24-bit colour and drives RGB, sync and blanking outputs to the DAC/connector, all aligned to the same pixel.

Parameters:
- CLK_DIV, 2, system clocks per pixel; legal range is ≥2 (50 MHz clk → 25 MHz pixel).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, pixels.
- H_SYNC, 96, hsync pulse width, pixels.
- H_BP, 48, horizontal back porch, pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, lines.
- V_SYNC, 2, vsync pulse width, lines.
- V_BP, 33, vertical back porch, lines.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- color_in  in  24  pixel colour from the graphics ASIC, {R[23:16], G[15:8], B[7:0]}.
- vga_ready  out  1  one-clk strobe per active pixel, requesting that pixel.
- frame_start  out  1  one-clk pulse coincident with the vga_ready for pixel (0,0).
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- blank_n  out  1  high while the displayed pixel is active.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.

Behaviour:
- Counters
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (`div` == CLK_DIV-1).
  - `h_cnt` counts 0..H_TOT-1, where H_TOT = 800. It increments on `pix_en` and wraps to 0.
  - `v_cnt` counts 0..V_TOT-1, where V_TOT = 525. It increments on `pix_en` when `h_cnt` == H_TOT-1, and wraps to 0 after line 524.
- Active region: `active` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- Fetch
  - `vga_ready` = !`rst` && (`div` == 0) && `active`. Decoded from registered counters: exactly one clk per pixel period.
  - 307200 strobes per frame, CLK_DIV clks apart within a line.
  - `frame_start` = !`rst` && (`div` == 0) && (`h_cnt` == 0) && (`v_cnt` == 0).
- Colour capture
  - At the posedge where `div` == 1, `color_hold` <= `color_in`.
  - `color_in` must be valid during the cycle after the strobe, i.e. a registered upstream response is allowed.
  - `color_in` is ignored at all other edges.
- Output stage, loaded at the `pix_en` edge of pixel (h,v):
  - `vga_r/g/b` <= `active` ? `color_hold` fields : 0.
  - `blank_n` <= `active`.
  - `hsync` <= !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for h in 656..751.
  - `vsync` <= !(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for v in 490..491.
  - Result: RGB, `blank_n` and syncs for a given pixel change together on one edge. That edge is CLK_DIV-1 clks after that pixel's `vga_ready` strobe.
  - Outputs hold for CLK_DIV clks.
- Blanking: RGB is forced to 0 whenever `blank_n` = 0, regardless of `color_in`.
- Reset
  - `div`, `h_cnt`, `v_cnt` and `color_hold` = 0.
  - `hsync` = 1, `vsync` = 1, `blank_n` = 0, RGB = 0.
  - `vga_ready` = 0 and `frame_start` = 0 while `rst` is high.
  - First clk after release: `vga_ready` = 1 and `frame_start` = 1 (pixel 0,0).
  - Reset asserted mid-frame aborts the frame immediately. No partial-line recovery; timing restarts at (0,0).
- Wrap
  - At `pix_en` with h = 799, v = 524: counters go to (0,0).
  - The next `div` == 0 cycle issues `frame_start` and `vga_ready`.
- No stall input: upstream must respond every strobe. A late colour is displayed as whatever `color_hold` captured.

Test Plan:
- Reset: hold rst 5 clks.
  - During reset: `hsync` = `vsync` = 1, `blank_n` = 0, RGB = 0, `vga_ready` = 0.
  - First clk after release: `vga_ready` = 1 and `frame_start` = 1.
- Strobe count, CLK_DIV = 2, over one full frame (2·800·525 = 840000 clks):
  - Exactly 307200 `vga_ready` pulses and one `frame_start`.
  - Consecutive in-line strobes exactly 2 clks apart.
  - Gap between the last strobe of line n and the first of line n+1 = 2·161 = 322 clks.
- Sync timing:
  - `hsync` low for 96 pixels (192 clks), starting at h = 656 of every line.
  - `vsync` low for exactly 2·800 pixels, starting at line 490.
  - `blank_n` low throughout porches and sync.
- Colour pipeline: respond to strobe k with `color_in` = {8'(x), 8'(y), 8'hA5}, valid the cycle after the strobe.
  - Pixel (5,3) displays R = 5, G = 3, B = A5, with `blank_n` = 1.
  - It appears 1 clk after its strobe and holds 2 clks.
- Blanking override: drive `color_in` = FFFFFF constantly. RGB = 0 at h = 640..799 and for lines 480..524.
- Mid-frame reset: assert rst at h = 300, v = 200 for one clk.
  - Outputs return to reset values.
  - Next strobe is (0,0) with `frame_start` = 1.
  - Following frame timing is identical to the first.

Source files
------------

// File: rtl/vga_scan_out.sv
// VGA 640x480@60 scan-out: pixel-enable divider, h/v timing counters, colour fetch strobe
// and a single registered output stage so RGB, blanking and syncs change on the same edge.
module vga_scan_out #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] color_in,
   output logic        vga_ready,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int H_W   = $clog2(H_TOT);
   localparam int V_W   = $clog2(V_TOT);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_CAP  = DIV_W'(1);
   localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOT - 1);
   localparam logic [H_W-1:0]   H_VIS    = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOT - 1);
   localparam logic [V_W-1:0]   V_VIS    = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div;
   logic [H_W-1:0]   h_cnt;
   logic [V_W-1:0]   v_cnt;
   logic [23:0]      color_hold;
   logic [23:0]      color_cur;
   logic             pix_en;
   logic             active;
   logic             h_sync_zone;
   logic             v_sync_zone;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pix_en      = (div == DIV_LAST);
      active      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      h_sync_zone = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
      v_sync_zone = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
      vga_ready   = !rst && (div == '0) && active;
      frame_start = !rst && (div == '0) && (h_cnt == '0) && (v_cnt == '0);
      // With CLK_DIV == 2 the capture edge is also the output edge, so forward the live colour.
      color_cur   = (div == DIV_CAP) ? color_in : color_hold;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         div        <= '0;
         h_cnt      <= '0;
         v_cnt      <= '0;
         color_hold <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         blank_n    <= 1'b0;
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
      end else begin
         div <= pix_en ? '0 : div + 1'b1;

         if (div == DIV_CAP)
            color_hold <= color_in;

         if (pix_en) begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
            if (h_cnt == H_LAST)
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;

            // Output stage for the pixel currently addressed by h_cnt/v_cnt.
            vga_r   <= active ? color_cur[23:16] : 8'h00;
            vga_g   <= active ? color_cur[15:8]  : 8'h00;
            vga_b   <= active ? color_cur[7:0]   : 8'h00;
            blank_n <= active;
            hsync   <= !h_sync_zone;
            vsync   <= !v_sync_zone;
         end
      end
   end

endmodule
